slave_ram_frame_tx: RTL and testbench
=====================================

Name: slave_ram_frame_tx

Overview:
- Downstream consumer of the slave dual-port block RAM read port (256 x 32, registered read, 1-cycle latency, output holds while ce is low).
- On a start pulse, reads a window of N words starting at a base address and serialises them as one frame on a 32-bit valid/ready stream toward the master link.
- Each frame is a header word, then the N data words, then an XOR checksum word.
- Full throughput of 1 word/cycle under continuous ready; correct under arbitrary backpressure.

Parameters:
- HDR_MAGIC, 16'hA55A, upper 16 bits of the header word
- RAM_AW, 8, RAM address width (depth 2^RAM_AW = 256)

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle start request, honoured only when idle
- i_base_addr  in  8  first RAM address of the window
- i_word_cnt  in  9  number of data words, 1..256
- o_slave_r_ram_addr  out  8  RAM read address
- o_slave_r_ram_ce  out  1  RAM read enable
- i_slave_r_ram_dout  in  32  RAM read data, valid the cycle after ce
- o_tx_data  out  32  stream data
- o_tx_valid  out  1  stream valid
- o_tx_last  out  1  high with the checksum word only
- i_tx_ready  in  1  stream ready
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse after the checksum word is accepted
- o_err  out  1  one-cycle pulse when a start with i_word_cnt = 0 is rejected

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: o_tx_valid, o_tx_last, o_busy, o_done, o_err, o_slave_r_ram_ce = 0; o_tx_data, o_slave_r_ram_addr = 0; checksum = 0; state = IDLE.
- Reset asserted mid-frame aborts the frame immediately. No o_done is generated, and the next start after reset begins a fresh frame.
- Start acceptance (cycle 0): i_start high in IDLE.
  - i_word_cnt = 0: o_err pulses in cycle 1 and the block stays in IDLE.
  - i_word_cnt > 256: saturates to 256.
  - Otherwise base address and count are latched. In the same cycle o_slave_r_ram_ce = 1 and o_slave_r_ram_addr = i_base_addr, both driven combinationally, to hide the RAM latency.
- i_start while busy is ignored; no error is flagged.
- States: IDLE -> HDR -> DATA -> CSUM -> IDLE.
- HDR (cycle 1): o_tx_valid = 1, o_tx_data = {HDR_MAGIC, 7'd0, count[8:0]}, o_busy = 1. Checksum is initialised to the header word. Holds until accepted.
- DATA: words are sent in order: addresses base, base+1, ... modulo 256 (wraps 255 -> 0).
  - A 2-entry output buffer absorbs the 1-cycle RAM latency.
  - A new read issues only when (buffered words + reads in flight) < 2 and reads remain.
  - o_slave_r_ram_ce is otherwise 0, so the RAM holds its output.
  - Every accepted data word is XORed into the checksum.
- CSUM: o_tx_data = running checksum, o_tx_valid = 1, o_tx_last = 1. When accepted, the next cycle has o_done = 1, o_busy = 0 and state IDLE.
- Handshake: a word transfers when o_tx_valid && i_tx_ready on a rising edge. Once o_tx_valid is raised, o_tx_data and o_tx_last stay stable until transfer. o_tx_valid never drops without a transfer.
- Latency with i_tx_ready held high: header in cycle 1, data k in cycle 2+k, checksum in cycle N+2, o_done in cycle N+3.
- A new start is accepted in the o_done cycle. Back-to-back frames therefore have a gap of exactly 1 cycle.
- RAM reads total exactly N per frame. No read is issued outside a frame.

Decomposition:
- Shared package: HDR_MAGIC, state encoding (IDLE/HDR/DATA/CSUM), header field offsets.
- Sub-module: frame_tx_skid_buf, a 2-entry FIFO with count output, fed by the RAM dout and in-flight flag and drained by the stream handshake.
- The FSM and checksum stay in the top module.

Test Plan:
- RAM preloaded with ram[i] = 32'h1000_0000+i. Start with base = 8'h10, cnt = 4, ready = 1.
  - Stream: 32'hA55A_0004, 32'h1000_0010..13, then checksum (XOR of all five) with last.
  - o_done in cycle 7; exactly 4 ce pulses.
- Wrap: base = 8'hFE, cnt = 4 -> data from addresses FE, FF, 00, 01 in that order; header 32'hA55A_0004.
- Backpressure: cnt = 8 with i_tx_ready toggling pseudo-randomly.
  - Data stays stable while valid && !ready.
  - No word is lost or duplicated, and the sequence and checksum match the ready = 1 case.
  - ce never issues with buffer+in-flight = 2.
- Boundaries:
  - cnt = 0 -> o_err pulse, no valid, busy stays 0.
  - cnt = 300 -> header length field 256 and 256 data words.
  - cnt = 256, base = 0 -> full RAM sent once.
- Start while busy is ignored, and the frame completes unchanged. Start in the o_done cycle is accepted, and its header appears the next cycle.
- Reset mid-DATA: deassert i_rst_n after 3 data words.
  - All outputs are 0 asynchronously and there is no o_done.
  - After release, a new start produces a correct full frame.

Source files
------------

// File: rtl/slave_ram_frame_tx_pkg.sv
// Shared definitions for the RAM-window frame transmitter: header layout,
// frame FSM encoding and the default header magic.
package slave_ram_frame_tx_pkg;

  localparam logic [15:0] HDR_MAGIC_DEF = 16'hA55A;
  localparam int          RAM_AW_DEF    = 8;

  localparam int          HDR_MAGIC_LSB = 16;
  localparam int          HDR_LEN_W     = 9;
  localparam logic [8:0]  MAX_WORDS     = 9'd256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM
  } tx_state_e;

  // Header word: magic in the upper half, word count in the low bits.
  function automatic logic [31:0] make_header(input logic [15:0] magic,
                                              input logic [HDR_LEN_W-1:0] len);
    logic [31:0] w;
    w = '0;
    w[HDR_MAGIC_LSB +: 16] = magic;
    w[HDR_LEN_W-1:0]       = len;
    return w;
  endfunction

endpackage

// File: rtl/slave_ram_frame_tx_skid_buf.sv
// Two-entry FIFO that catches RAM read data one cycle after each read and
// presents the oldest word to the stream.
module frame_tx_skid_buf (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  logic [31:0] i_data,
  input  logic        i_pop,
  output logic [31:0] o_head,
  output logic [1:0]  o_count
);

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (i_push) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (i_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign o_head  = mem[rd_ptr];
  assign o_count = count;

endmodule

// File: rtl/slave_ram_frame_tx.sv
// Reads a window of words from the slave RAM and sends it as one
// header / data / XOR-checksum frame on a valid/ready stream.
module slave_ram_frame_tx
  import slave_ram_frame_tx_pkg::*;
#(
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF,
  parameter int          RAM_AW    = RAM_AW_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [RAM_AW-1:0] i_base_addr,
  input  logic [8:0]        i_word_cnt,
  output logic [RAM_AW-1:0] o_slave_r_ram_addr,
  output logic              o_slave_r_ram_ce,
  input  logic [31:0]       i_slave_r_ram_dout,
  output logic [31:0]       o_tx_data,
  output logic              o_tx_valid,
  output logic              o_tx_last,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  tx_state_e         state_q, state_d;
  logic [8:0]        len_q, rd_left_q, tx_left_q, len_sat;
  logic [RAM_AW-1:0] rd_addr_q;
  logic              inflight_q;
  logic [31:0]       csum_q;
  logic              done_q, err_q;
  logic [31:0]       buf_head;
  logic [1:0]        buf_count;
  logic [2:0]        occ;
  logic              start_ok, start_bad, pop, issue_data;

  assign len_sat   = (i_word_cnt > MAX_WORDS) ? MAX_WORDS : i_word_cnt;
  assign start_ok  = (state_q == ST_IDLE) && i_start && (i_word_cnt != 9'd0);
  assign start_bad = (state_q == ST_IDLE) && i_start && (i_word_cnt == 9'd0);

  assign o_tx_valid = (state_q == ST_HDR) || (state_q == ST_CSUM) ||
                      ((state_q == ST_DATA) && (buf_count != 2'd0));
  assign pop        = (state_q == ST_DATA) && (buf_count != 2'd0) && i_tx_ready;

  // Slots committed once this cycle's drain is counted; keeps 1 word/cycle
  // while never letting buffered plus in-flight words exceed two.
  assign occ        = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue_data = ((state_q == ST_HDR) || (state_q == ST_DATA)) &&
                      (rd_left_q != 9'd0) && (occ < 3'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    o_tx_data = '0;
    o_tx_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_HDR;
      end
      ST_HDR: begin
        o_tx_data = make_header(HDR_MAGIC, len_q);
        if (i_tx_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        o_tx_data = buf_head;
        if (pop && (tx_left_q == 9'd1)) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        o_tx_data = csum_q;
        o_tx_last = 1'b1;
        if (i_tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The first read goes out in the start cycle to hide the RAM latency.
  always_comb begin
    o_slave_r_ram_ce   = 1'b0;
    o_slave_r_ram_addr = '0;
    if (start_ok) begin
      o_slave_r_ram_ce   = 1'b1;
      o_slave_r_ram_addr = i_base_addr;
    end else if (issue_data) begin
      o_slave_r_ram_ce   = 1'b1;
      o_slave_r_ram_addr = rd_addr_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q      <= '0;
      rd_left_q  <= '0;
      tx_left_q  <= '0;
      rd_addr_q  <= '0;
      csum_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q     <= len_sat;
        rd_left_q <= len_sat - 9'd1;
        tx_left_q <= len_sat;
        rd_addr_q <= i_base_addr + 1'b1;
        csum_q    <= make_header(HDR_MAGIC, len_sat);
      end else begin
        if (issue_data) begin
          rd_addr_q <= rd_addr_q + 1'b1;
          rd_left_q <= rd_left_q - 9'd1;
        end
        if (pop) begin
          tx_left_q <= tx_left_q - 9'd1;
          csum_q    <= csum_q ^ buf_head;
        end
      end
      inflight_q <= o_slave_r_ram_ce;
      done_q     <= (state_q == ST_CSUM) && i_tx_ready;
      err_q      <= start_bad;
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = done_q;
  assign o_err  = err_q;

  frame_tx_skid_buf u_skid_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (inflight_q),
    .i_data  (i_slave_r_ram_dout),
    .i_pop   (pop),
    .o_head  (buf_head),
    .o_count (buf_count)
  );

endmodule

// File: tb/tb_slave_ram_frame_tx.sv
// Directed, table-driven bench for slave_ram_frame_tx with a registered-read
// RAM model preloaded with ram[i] = 32'h1000_0000 + i.
module tb_slave_ram_frame_tx;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  cnt;
    bit          rnd;
    bit          exp_err;
    logic [31:0] exp_hdr;
    int          exp_n;
    logic [31:0] exp_csum;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_base_addr;
  logic [8:0]  i_word_cnt;
  logic [7:0]  o_slave_r_ram_addr;
  logic        o_slave_r_ram_ce;
  logic [31:0] i_slave_r_ram_dout = '0;
  logic [31:0] o_tx_data;
  logic        o_tx_valid;
  logic        o_tx_last;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] ram [256];
  vec_t        vecs [10];

  slave_ram_frame_tx dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_start            (i_start),
    .i_base_addr        (i_base_addr),
    .i_word_cnt         (i_word_cnt),
    .o_slave_r_ram_addr (o_slave_r_ram_addr),
    .o_slave_r_ram_ce   (o_slave_r_ram_ce),
    .i_slave_r_ram_dout (i_slave_r_ram_dout),
    .o_tx_data          (o_tx_data),
    .o_tx_valid         (o_tx_valid),
    .o_tx_last          (o_tx_last),
    .i_tx_ready         (i_tx_ready),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_err              (o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + 32'(i);
  end

  always @(posedge i_clk) begin
    if (o_slave_r_ram_ce) i_slave_r_ram_dout <= ram[o_slave_r_ram_addr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(o_tx_valid), 0);
    checkOutput({tag, "_last"},  32'(o_tx_last), 0);
    checkOutput({tag, "_busy"},  32'(o_busy), 0);
    checkOutput({tag, "_done"},  32'(o_done), 0);
    checkOutput({tag, "_err"},   32'(o_err), 0);
    checkOutput({tag, "_ce"},    32'(o_slave_r_ram_ce), 0);
    checkOutput({tag, "_data"},  o_tx_data, 0);
    checkOutput({tag, "_addr"},  32'(o_slave_r_ram_addr), 0);
  endtask

  // Runs one frame. If started is set, the start was already accepted in the
  // previous cycle (chained from a done cycle).
  task automatic applyStimulus(input vec_t v, input bit started, input int poke_cycle,
                               input bit chain, input vec_t nv);
    int          cycle, xfer, issued, data_acc, limit;
    bit          done_seen, hold, hold_last, pop_now;
    logic [31:0] hold_data;
    logic [7:0]  a;
    if (!started) begin
      @(negedge i_clk);
      i_base_addr = v.base;
      i_word_cnt  = v.cnt;
      i_start     = 1'b1;
      i_tx_ready  = 1'b1;
      #1;
      checkOutput("start_ce", 32'(o_slave_r_ram_ce), v.exp_err ? 0 : 1);
      if (!v.exp_err) checkOutput("start_addr", 32'(o_slave_r_ram_addr), 32'(v.base));
    end
    @(negedge i_clk);
    i_start = 1'b0;
    if (v.exp_err) begin
      #1;
      checkOutput("err_pulse", 32'(o_err), 1);
      checkOutput("err_valid", 32'(o_tx_valid), 0);
      checkOutput("err_busy",  32'(o_busy), 0);
      checkOutput("err_ce",    32'(o_slave_r_ram_ce), 0);
      @(negedge i_clk);
      #1;
      checkOutput("err_clear",      32'(o_err), 0);
      checkOutput("err_busy_after", 32'(o_busy), 0);
      checkOutput("err_valid_after", 32'(o_tx_valid), 0);
      return;
    end
    issued = 1; data_acc = 0; xfer = 0; hold = 0; hold_last = 0; hold_data = '0;
    done_seen = 0; cycle = 1; limit = 4 * v.exp_n + 40;
    while (!done_seen && cycle <= limit) begin
      i_tx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_cycle != 0 && cycle == poke_cycle) begin
        i_start = 1'b1; i_base_addr = 8'h80; i_word_cnt = 9'd2;
      end
      #1;
      if (cycle == 1) checkOutput("busy_hdr", 32'(o_busy), 1);
      if (poke_cycle != 0 && cycle == poke_cycle + 1)
        checkOutput("busy_start_no_err", 32'(o_err), 0);
      if (o_done) begin
        done_seen = 1;
        checkOutput("done_busy",   32'(o_busy), 0);
        checkOutput("frame_words", 32'(xfer), 32'(v.exp_n + 2));
        checkOutput("ram_reads",   32'(issued), 32'(v.exp_n));
        if (!v.rnd) checkOutput("done_cycle", 32'(cycle), 32'(v.exp_n + 3));
        if (chain) begin
          i_base_addr = nv.base; i_word_cnt = nv.cnt; i_start = 1'b1;
          #1;
          checkOutput("chain_ce",   32'(o_slave_r_ram_ce), 1);
          checkOutput("chain_addr", 32'(o_slave_r_ram_addr), 32'(nv.base));
        end
      end else begin
        if (hold) begin
          checkOutput("hold_valid", 32'(o_tx_valid), 1);
          checkOutput("hold_data",  o_tx_data, hold_data);
          checkOutput("hold_last",  32'(o_tx_last), 32'(hold_last));
        end
        pop_now = o_tx_valid && i_tx_ready && xfer >= 1 && xfer <= v.exp_n;
        if (o_slave_r_ram_ce) begin
          a = v.base + 8'(issued);
          checkOutput("ce_addr", 32'(o_slave_r_ram_addr), 32'(a));
          checkOutput("ce_room", 32'((issued - data_acc - int'(pop_now)) < 2), 1);
          issued++;
        end
        if (o_tx_valid && i_tx_ready) begin
          if (xfer == 0) begin
            checkOutput("hdr",      o_tx_data, v.exp_hdr);
            checkOutput("hdr_last", 32'(o_tx_last), 0);
            if (!v.rnd) checkOutput("hdr_cycle", 32'(cycle), 1);
          end else if (xfer <= v.exp_n) begin
            a = v.base + 8'(xfer - 1);
            checkOutput("data",      o_tx_data, 32'h1000_0000 + {24'd0, a});
            checkOutput("data_last", 32'(o_tx_last), 0);
            data_acc++;
          end else begin
            checkOutput("csum",      o_tx_data, v.exp_csum);
            checkOutput("csum_last", 32'(o_tx_last), 1);
            if (!v.rnd) checkOutput("csum_cycle", 32'(cycle), 32'(v.exp_n + 2));
          end
          xfer++;
        end
        hold      = o_tx_valid && !i_tx_ready;
        hold_data = o_tx_data;
        hold_last = o_tx_last;
        @(negedge i_clk);
        i_start = 1'b0;
        cycle++;
      end
    end
    checkOutput("done_seen", 32'(done_seen), 1);
  endtask

  initial begin
    vec_t none;
    vecs[0] = '{8'h10, 9'd4,   0, 0, 32'hA55A_0004, 4,   32'hA55A_0004};
    vecs[1] = '{8'hFE, 9'd4,   0, 0, 32'hA55A_0004, 4,   32'hA55A_0004};
    vecs[2] = '{8'h20, 9'd3,   0, 0, 32'hA55A_0003, 3,   32'hB55A_0020};
    vecs[3] = '{8'h05, 9'd1,   0, 0, 32'hA55A_0001, 1,   32'hB55A_0004};
    vecs[4] = '{8'h10, 9'd8,   1, 0, 32'hA55A_0008, 8,   32'hA55A_0008};
    vecs[5] = '{8'h00, 9'd0,   0, 1, 32'h0,         0,   32'h0};
    vecs[6] = '{8'h00, 9'd300, 0, 0, 32'hA55A_0100, 256, 32'hA55A_0100};
    vecs[7] = '{8'h00, 9'd256, 0, 0, 32'hA55A_0100, 256, 32'hA55A_0100};
    vecs[8] = '{8'h80, 9'd256, 1, 0, 32'hA55A_0100, 256, 32'hA55A_0100};
    vecs[9] = '{8'hFF, 9'd3,   0, 0, 32'hA55A_0003, 3,   32'hB55A_00FD};
    none    = vecs[0];

    i_rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_word_cnt = '0; i_tx_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    checkAllZero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      $display("[TB] vector %0d: base=%h cnt=%0d", k, vecs[k].base, vecs[k].cnt);
      applyStimulus(vecs[k], 1'b0, 0, 1'b0, none);
    end

    // Start while busy is ignored; start in the done cycle chains a frame.
    $display("[TB] busy-start and chained frame");
    applyStimulus(vecs[0], 1'b0, 2, 1'b1, vecs[2]);
    applyStimulus(vecs[2], 1'b1, 0, 1'b0, none);

    // Reset after three data words have been accepted.
    $display("[TB] reset mid-frame");
    @(negedge i_clk);
    i_base_addr = 8'h10; i_word_cnt = 9'd8; i_start = 1'b1; i_tx_ready = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      #1;
      checkOutput("midrst_no_done", 32'(o_done), 0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checkOutput("post_rst_done", 32'(o_done), 0);
    checkOutput("post_rst_busy", 32'(o_busy), 0);
    applyStimulus(vecs[2], 1'b0, 0, 1'b0, none);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
